// File: rtl/dev_tx_cmd_arbiter_pkg.sv
// Shared definitions for the TX command arbiter: one-hot state encodings and the cmd_len field width.
package dev_tx_cmd_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_XFER = 3'b010,
      S_GAP  = 3'b100
   } arb_state_e;

   localparam int CMD_LEN_W = 2;

endpackage

// File: rtl/dev_tx_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above start_i, wrapping modulo P_NUM_REQ.
module dev_tx_cmd_rr_pick #(
   parameter int P_NUM_REQ       = 4,
   parameter int P_REQ_IDX_WIDTH = 2
) (
   input  logic [P_NUM_REQ-1:0]       req_i,
   input  logic [P_REQ_IDX_WIDTH-1:0] start_i,
   output logic                       found_o,
   output logic [P_REQ_IDX_WIDTH-1:0] idx_o
);

   localparam logic [P_REQ_IDX_WIDTH:0] NUM = (P_REQ_IDX_WIDTH+1)'(P_NUM_REQ);

   logic [P_REQ_IDX_WIDTH:0]   sum;
   logic [P_REQ_IDX_WIDTH-1:0] cand;

   // start_i and the offset are both below P_NUM_REQ, so one subtraction wraps the sum
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      cand    = '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         sum = {1'b0, start_i} + (P_REQ_IDX_WIDTH+1)'(k);
         if (sum >= NUM) sum = sum - NUM;
         cand = sum[P_REQ_IDX_WIDTH-1:0];
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/dev_tx_cmd_arbiter.sv
// Round-robin arbiter for the device TX command FIFO write port; grant is held for a whole 1-4 beat command.
// Define DEV_TX_CMD_ARB_PRIO0_EN to give requester 0 strict priority over the rotating others.
module dev_tx_cmd_arbiter
   import dev_tx_cmd_arbiter_pkg::*;
#(
   parameter int P_NUM_REQ        = 4,
   parameter int P_REQ_IDX_WIDTH  = 2,
   parameter int P_CMD_DATA_WIDTH = 30
) (
   input  logic                                  pcie_user_clk,
   input  logic                                  pcie_user_rst_n,
   input  logic [P_NUM_REQ-1:0]                  cmd_req,
   input  logic [CMD_LEN_W*P_NUM_REQ-1:0]        cmd_len,
   input  logic [P_CMD_DATA_WIDTH*P_NUM_REQ-1:0] cmd_data,
   output logic [P_NUM_REQ-1:0]                  cmd_ack,
   output logic                                  tx_cmd_wr_en,
   output logic [P_CMD_DATA_WIDTH-1:0]           tx_cmd_wr_data,
   input  logic                                  tx_cmd_full_n,
   output logic                                  arb_busy
);

   localparam logic [P_REQ_IDX_WIDTH-1:0] LAST_IDX = P_REQ_IDX_WIDTH'(P_NUM_REQ - 1);

   arb_state_e                 state_q, state_d;
   logic [P_REQ_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [P_REQ_IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic [CMD_LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [CMD_LEN_W-1:0]       last_beat_q, last_beat_d;

   logic [P_CMD_DATA_WIDTH-1:0] data_arr [P_NUM_REQ];
   logic [CMD_LEN_W-1:0]        len_arr  [P_NUM_REQ];

   for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = cmd_data[g*P_CMD_DATA_WIDTH +: P_CMD_DATA_WIDTH];
      assign len_arr[g]  = cmd_len[g*CMD_LEN_W +: CMD_LEN_W];
   end

   logic [P_NUM_REQ-1:0]       pick_req;
   logic                       pick_found;
   logic [P_REQ_IDX_WIDTH-1:0] pick_idx;
   logic [P_REQ_IDX_WIDTH-1:0] next_ptr;

`ifdef DEV_TX_CMD_ARB_PRIO0_EN
   // requester 0 is served outside the rotation, so the picker never sees it
   assign pick_req = {cmd_req[P_NUM_REQ-1:1], 1'b0};
`else
   assign pick_req = cmd_req;
`endif

   dev_tx_cmd_rr_pick #(
      .P_NUM_REQ       (P_NUM_REQ),
      .P_REQ_IDX_WIDTH (P_REQ_IDX_WIDTH)
   ) u_rr_pick (
      .req_i   (pick_req),
      .start_i (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign next_ptr       = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
   assign tx_cmd_wr_data = data_arr[grant_idx_q];
   assign arb_busy       = (state_q != S_IDLE);

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         beat_cnt_q  <= '0;
         last_beat_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         beat_cnt_q  <= beat_cnt_d;
         last_beat_q <= last_beat_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_idx_d  = grant_idx_q;
      beat_cnt_d   = beat_cnt_q;
      last_beat_d  = last_beat_q;
      tx_cmd_wr_en = 1'b0;
      cmd_ack      = '0;

      unique case (state_q)
         S_IDLE: begin
`ifdef DEV_TX_CMD_ARB_PRIO0_EN
            if (cmd_req[0]) begin
               grant_idx_d = '0;
               last_beat_d = len_arr[0];
               beat_cnt_d  = '0;
               state_d     = S_XFER;
            end else if (pick_found) begin
`else
            if (pick_found) begin
`endif
               grant_idx_d = pick_idx;
               last_beat_d = len_arr[pick_idx];
               beat_cnt_d  = '0;
               state_d     = S_XFER;
            end
         end
         S_XFER: begin
            // write strobe follows full_n combinationally so a full FIFO is never written
            tx_cmd_wr_en = tx_cmd_full_n;
            if (tx_cmd_full_n) begin
               cmd_ack[grant_idx_q] = 1'b1;
               beat_cnt_d           = beat_cnt_q + 1'b1;
               if (beat_cnt_q == last_beat_q) begin
                  state_d = S_GAP;
`ifdef DEV_TX_CMD_ARB_PRIO0_EN
                  if (grant_idx_q != '0) rr_ptr_d = next_ptr;
`else
                  rr_ptr_d = next_ptr;
`endif
               end
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dev_tx_cmd_arbiter.sv
// Directed self-checking bench for dev_tx_cmd_arbiter (default build and DEV_TX_CMD_ARB_PRIO0_EN build).
module tb_dev_tx_cmd_arbiter;

   localparam int N  = 4;
   localparam int DW = 30;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  cmd_req;
   logic [2*N-1:0] cmd_len;
   logic [DW*N-1:0] cmd_data;
   logic [N-1:0]  cmd_ack;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full_n;
   logic          busy;

   logic [DW-1:0] dat [N];
   logic [1:0]    len [N];

   int checks = 0;
   int errors = 0;

   always_comb begin
      cmd_data = {dat[3], dat[2], dat[1], dat[0]};
      cmd_len  = {len[3], len[2], len[1], len[0]};
   end

   dev_tx_cmd_arbiter #(
      .P_NUM_REQ        (N),
      .P_REQ_IDX_WIDTH  (2),
      .P_CMD_DATA_WIDTH (DW)
   ) dut (
      .pcie_user_clk   (clk),
      .pcie_user_rst_n (rst_n),
      .cmd_req         (cmd_req),
      .cmd_len         (cmd_len),
      .cmd_data        (cmd_data),
      .cmd_ack         (cmd_ack),
      .tx_cmd_wr_en    (wr_en),
      .tx_cmd_wr_data  (wr_data),
      .tx_cmd_full_n   (full_n),
      .arb_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one single-beat command from requester g: XFER, GAP, IDLE
   task automatic rr_cmd(input int g, input string tag);
      @(negedge clk); #1;
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd1);
      chk({tag, "_ack"},   {28'd0, cmd_ack}, 32'd1 << g);
      chk({tag, "_data"},  {2'd0, wr_data}, 32'h100 + g);
      @(negedge clk); #1;
      chk({tag, "_gap_wr"},   {31'd0, wr_en}, 32'd0);
      chk({tag, "_gap_busy"}, {31'd0, busy},  32'd1);
      @(negedge clk); #1;
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      cmd_req = '0;
      full_n  = 1'b1;
      for (int i = 0; i < N; i++) begin
         dat[i] = '0;
         len[i] = '0;
      end

      // reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_ack",   {28'd0, cmd_ack}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      rst_n = 1'b1;

      // requester 2, four beats
      @(negedge clk);
      cmd_req = 4'b0100; len[2] = 2'd3; dat[2] = 30'h2A0;
      #1;
      chk("t1_idle_wr", {31'd0, wr_en}, 32'd0);
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         dat[2] = 30'h2A0 + 30'(k);
         #1;
         chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
         chk("t1_ack",   {28'd0, cmd_ack}, 32'h4);
         chk("t1_data",  {2'd0, wr_data}, 32'h2A0 + k);
      end
      @(negedge clk);
      cmd_req = '0;
      #1;
      chk("t1_gap_wr", {31'd0, wr_en}, 32'd0);
      chk("t1_gap_busy", {31'd0, busy}, 32'd1);
      @(negedge clk); #1;
      chk("t1_end_busy", {31'd0, busy}, 32'd0);

      // all four requesting single-beat commands from rr_ptr 0
      pulse_reset();
      for (int i = 0; i < N; i++) begin
         dat[i] = 30'h100 + 30'(i);
         len[i] = 2'd0;
      end
      cmd_req = 4'b1111;
      #1;
      chk("t2_idle_busy", {31'd0, busy}, 32'd0);
`ifdef DEV_TX_CMD_ARB_PRIO0_EN
      rr_cmd(0, "t2_g0"); rr_cmd(0, "t2_g1"); rr_cmd(0, "t2_g2"); rr_cmd(0, "t2_g3"); rr_cmd(0, "t2_g4");
`else
      rr_cmd(0, "t2_g0"); rr_cmd(1, "t2_g1"); rr_cmd(2, "t2_g2"); rr_cmd(3, "t2_g3"); rr_cmd(0, "t2_g4");
`endif
      cmd_req = '0;

      // requester 1, three beats, FIFO full for 5 cycles after beat 0
      @(negedge clk);
      cmd_req = 4'b0010; len[1] = 2'd2; dat[1] = 30'hA0;
      @(negedge clk); #1;
      chk("t3_b0_wr",   {31'd0, wr_en}, 32'd1);
      chk("t3_b0_ack",  {28'd0, cmd_ack}, 32'h2);
      chk("t3_b0_data", {2'd0, wr_data}, 32'hA0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         dat[1] = 30'hA1; full_n = 1'b0;
         #1;
         chk("t3_stall_wr",  {31'd0, wr_en}, 32'd0);
         chk("t3_stall_ack", {28'd0, cmd_ack}, 32'd0);
      end
      @(negedge clk);
      full_n = 1'b1;
      #1;
      chk("t3_b1_wr",   {31'd0, wr_en}, 32'd1);
      chk("t3_b1_ack",  {28'd0, cmd_ack}, 32'h2);
      chk("t3_b1_data", {2'd0, wr_data}, 32'hA1);
      @(negedge clk);
      dat[1] = 30'hA2;
      #1;
      chk("t3_b2_wr",   {31'd0, wr_en}, 32'd1);
      chk("t3_b2_data", {2'd0, wr_data}, 32'hA2);
      @(negedge clk);
      cmd_req = '0;
      #1;
      chk("t3_gap_wr", {31'd0, wr_en}, 32'd0);
      @(negedge clk);

      // requester 3 mid-command when requester 0 arrives
      cmd_req = 4'b1000; len[3] = 2'd2; dat[3] = 30'hC0;
      @(negedge clk); #1;
      chk("t4_c0_ack",  {28'd0, cmd_ack}, 32'h8);
      chk("t4_c0_data", {2'd0, wr_data}, 32'hC0);
      @(negedge clk);
      dat[3] = 30'hC1; cmd_req = 4'b1001; len[0] = 2'd0; dat[0] = 30'hD0;
      #1;
      chk("t4_c1_ack",  {28'd0, cmd_ack}, 32'h8);
      chk("t4_c1_data", {2'd0, wr_data}, 32'hC1);
      @(negedge clk);
      dat[3] = 30'hC2;
      #1;
      chk("t4_c2_ack",  {28'd0, cmd_ack}, 32'h8);
      chk("t4_c2_data", {2'd0, wr_data}, 32'hC2);
      @(negedge clk);
      cmd_req = 4'b0001;
      #1;
      chk("t4_gap_wr", {31'd0, wr_en}, 32'd0);
      chk("t4_gap_busy", {31'd0, busy}, 32'd1);
      @(negedge clk); #1;
      chk("t4_idle_wr", {31'd0, wr_en}, 32'd0);
      chk("t4_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); #1;
      chk("t4_d0_ack",  {28'd0, cmd_ack}, 32'h1);
      chk("t4_d0_data", {2'd0, wr_data}, 32'hD0);
      @(negedge clk);
      cmd_req = '0;
      @(negedge clk);

      // reset during a transfer; afterwards grant restarts from pointer 0
      cmd_req = 4'b0100; len[2] = 2'd3; dat[2] = 30'h200;
      @(negedge clk); #1;
      chk("t5_xfer_ack", {28'd0, cmd_ack}, 32'h4);
      @(negedge clk);
      rst_n = 1'b0; cmd_req = 4'b0101; dat[0] = 30'h300; len[0] = 2'd0;
      #1;
      chk("t5_rst_wr",   {31'd0, wr_en}, 32'd0);
      chk("t5_rst_ack",  {28'd0, cmd_ack}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); #1;
      chk("t5_g_ack",  {28'd0, cmd_ack}, 32'h1);
      chk("t5_g_data", {2'd0, wr_data}, 32'h300);
      @(negedge clk);
      cmd_req = '0;
      #1;
      chk("t5_gap_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);

      // requesters 1..3 rotate, then 0 and 2 compete
      for (int i = 0; i < N; i++) begin
         dat[i] = 30'h100 + 30'(i);
         len[i] = 2'd0;
      end
      cmd_req = 4'b1110;
      rr_cmd(1, "t6_a0"); rr_cmd(2, "t6_a1"); rr_cmd(3, "t6_a2"); rr_cmd(1, "t6_a3");
      cmd_req = 4'b0101;
`ifdef DEV_TX_CMD_ARB_PRIO0_EN
      rr_cmd(0, "t6_b0"); rr_cmd(0, "t6_b1"); rr_cmd(0, "t6_b2");
`else
      rr_cmd(2, "t6_b0"); rr_cmd(0, "t6_b1"); rr_cmd(2, "t6_b2");
`endif
      cmd_req = '0;
      @(negedge clk); #1;
      chk("t6_end_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
